// File: rtl/msrv32_irq_pkg.sv
// Shared constants for the msrv32 interrupt controller: register word
// addresses and the width of a source ID (IDs 1..31, 0 means "none").
package msrv32_irq_pkg;

  localparam int ID_W = 5;

  localparam logic [6:0] ADDR_PRIO_BASE = 7'h01;
  localparam logic [6:0] ADDR_PENDING   = 7'h40;
  localparam logic [6:0] ADDR_ENABLE    = 7'h41;
  localparam logic [6:0] ADDR_THRESHOLD = 7'h42;
  localparam logic [6:0] ADDR_CLAIM     = 7'h43;

endpackage

// File: rtl/msrv32_irq_prio_tree.sv
// Combinational selection of the highest-priority requesting source.
// A source must request with priority > 0 to win; on equal priority the
// lowest ID wins because only a strictly greater priority replaces the
// current best while scanning upward from ID 1.
module msrv32_irq_prio_tree
  import msrv32_irq_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic [NUM_SRC:1]             req,
  input  logic [NUM_SRC:1][PRIO_W-1:0] prio,
  output logic [ID_W-1:0]              max_id,
  output logic [PRIO_W-1:0]            max_prio
);

  // Scan all sources, keeping the first one with the strictly highest priority
  always_comb begin
    max_id   = '0;
    max_prio = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (req[i] && (prio[i] > max_prio)) begin
        max_prio = prio[i];
        max_id   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/msrv32_irq_ctrl.sv
// msrv32 external interrupt controller: per-source level/edge gateways,
// pending / in-service / deferred tracking, priority selection against a
// threshold, and a claim/complete register interface with one-cycle reads.
module msrv32_irq_ctrl
  import msrv32_irq_pkg::*;
#(
  parameter int                 NUM_SRC   = 8,
  parameter int                 PRIO_W    = 3,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '0
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [NUM_SRC-1:0] src_irq_in,
  input  logic               reg_wr_en_in,
  input  logic               reg_rd_en_in,
  input  logic [6:0]         reg_addr_in,
  input  logic [31:0]        reg_wdata_in,
  output logic [31:0]        reg_rdata_out,
  output logic               e_irq_out
);

  logic [NUM_SRC:1][PRIO_W-1:0] prio_reg, prio_next;
  logic [NUM_SRC:1]             enable_reg, enable_next;
  logic [NUM_SRC:1]             pending_reg, pending_next;
  logic [NUM_SRC:1]             in_service_reg, in_service_next;
  logic [NUM_SRC:1]             deferred_reg, deferred_next;
  logic [NUM_SRC:1]             edge_prev_reg;
  logic [PRIO_W-1:0]            threshold_reg, threshold_next;
  logic [31:0]                  rdata_reg, rdata_next;
  logic                         e_irq_reg, e_irq_next;

  logic [ID_W-1:0]   max_id;
  logic [PRIO_W-1:0] max_prio;
  logic              claim_en;
  logic              complete_en;
  logic [ID_W-1:0]   complete_id;

  // A claim is a read of the claim register; a complete is a write of a
  // clean ID (upper bits zero) to the same address.
  assign claim_en    = reg_rd_en_in && (reg_addr_in == ADDR_CLAIM);
  assign complete_en = reg_wr_en_in && (reg_addr_in == ADDR_CLAIM) &&
                       (reg_wdata_in[31:ID_W] == '0);
  assign complete_id = reg_wdata_in[ID_W-1:0];

  assign enable_next    = (reg_wr_en_in && reg_addr_in == ADDR_ENABLE) ?
                          reg_wdata_in[NUM_SRC:1] : enable_reg;
  assign threshold_next = (reg_wr_en_in && reg_addr_in == ADDR_THRESHOLD) ?
                          reg_wdata_in[PRIO_W-1:0] : threshold_reg;

  msrv32_irq_prio_tree #(
    .NUM_SRC (NUM_SRC),
    .PRIO_W  (PRIO_W)
  ) u_prio_tree (
    .req      (pending_reg & enable_reg),
    .prio     (prio_reg),
    .max_id   (max_id),
    .max_prio (max_prio)
  );

  // Per-source gateway and claim/complete bookkeeping
  for (genvar gi = 1; gi <= NUM_SRC; gi++) begin : g_src
    localparam logic IS_EDGE = EDGE_MASK[gi-1];
    logic src_line, rise, claim_hit, complete_hit, set_pend, set_def;

    assign src_line     = src_irq_in[gi-1];
    assign rise         = src_line && !edge_prev_reg[gi];
    assign claim_hit    = claim_en && (max_id == ID_W'(gi));
    assign complete_hit = complete_en && (complete_id == ID_W'(gi)) && in_service_reg[gi];

    // Idle source: a level source pends while high, an edge source on 0->1.
    assign set_pend = (IS_EDGE ? rise : src_line) &&
                      !pending_reg[gi] && !in_service_reg[gi] && !deferred_reg[gi];
    // An edge arriving during service is remembered once; further edges drop.
    assign set_def  = IS_EDGE && rise && in_service_reg[gi] &&
                      !pending_reg[gi] && !deferred_reg[gi];

    assign pending_next[gi]    = (pending_reg[gi] && !claim_hit) || set_pend ||
                                 (complete_hit && (deferred_reg[gi] || set_def));
    assign deferred_next[gi]   = (deferred_reg[gi] || set_def) && !complete_hit;
    assign in_service_next[gi] = (in_service_reg[gi] && !complete_hit) || claim_hit;
    assign prio_next[gi]       = (reg_wr_en_in && reg_addr_in == ADDR_PRIO_BASE + 7'(gi - 1)) ?
                                 reg_wdata_in[PRIO_W-1:0] : prio_reg[gi];
  end

  // Read mux; the claim register returns the pre-edge selection
  always_comb begin
    rdata_next = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (reg_addr_in == ADDR_PRIO_BASE + 7'(i - 1)) rdata_next[PRIO_W-1:0] = prio_reg[i];
    end
    if (reg_addr_in == ADDR_PENDING)   rdata_next[NUM_SRC:1] = pending_reg;
    if (reg_addr_in == ADDR_ENABLE)    rdata_next[NUM_SRC:1] = enable_reg;
    if (reg_addr_in == ADDR_THRESHOLD) rdata_next[PRIO_W-1:0] = threshold_reg;
    if (reg_addr_in == ADDR_CLAIM)     rdata_next[ID_W-1:0] = max_id;
  end

  assign e_irq_next = (max_prio > threshold_reg);

  // Controller state registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prio_reg       <= '0;
      enable_reg     <= '0;
      threshold_reg  <= '0;
      pending_reg    <= '0;
      in_service_reg <= '0;
      deferred_reg   <= '0;
      edge_prev_reg  <= '0;
    end else begin
      prio_reg       <= prio_next;
      enable_reg     <= enable_next;
      threshold_reg  <= threshold_next;
      pending_reg    <= pending_next;
      in_service_reg <= in_service_next;
      deferred_reg   <= deferred_next;
      edge_prev_reg  <= src_irq_in;
    end
  end

  // Registered read data (held between reads) and interrupt request
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rdata_reg <= '0;
      e_irq_reg <= 1'b0;
    end else begin
      if (reg_rd_en_in) rdata_reg <= rdata_next;
      e_irq_reg <= e_irq_next;
    end
  end

  assign reg_rdata_out = rdata_reg;
  assign e_irq_out     = e_irq_reg;

endmodule

// File: tb/tb_msrv32_irq_ctrl.sv
// Directed bench for msrv32_irq_ctrl (8 sources, 3-bit priority, source 8
// edge-triggered): a vector table for register access and basic selection,
// then hand-written sequences for deferred edges, level re-pend and reset.
module tb_msrv32_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src;
  logic        wr_en, rd_en;
  logic [6:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        e_irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msrv32_irq_ctrl #(
    .NUM_SRC   (8),
    .PRIO_W    (3),
    .EDGE_MASK (8'h80)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .src_irq_in    (src),
    .reg_wr_en_in  (wr_en),
    .reg_rd_en_in  (rd_en),
    .reg_addr_in   (addr),
    .reg_wdata_in  (wdata),
    .reg_rdata_out (rdata),
    .e_irq_out     (e_irq)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  src;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_irq;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr_i, input logic rd_i, input logic [6:0] a,
                              input logic [31:0] d, input logic [7:0] s,
                              input logic c_rd, input logic [31:0] e_rd,
                              input logic c_irq, input logic e_i);
    vec_t v;
    v.wr = wr_i; v.rd = rd_i; v.addr = a; v.wdata = d; v.src = s;
    v.chk_rd = c_rd; v.exp_rd = e_rd; v.chk_irq = c_irq; v.exp_irq = e_i;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [6:0] a, input logic [31:0] exp);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
    check(name, rdata, exp);
  endtask

  initial begin
    rst = 1'b1; src = '0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    repeat (2) tick();
    check("reset_rdata", rdata, 32'h0);
    check("reset_e_irq", {31'b0, e_irq}, 32'h0);
    rst = 1'b0;

    //                wr    rd    addr   wdata         src    chk_rd exp_rd        chk_irq exp_irq
    vecs.push_back(mk(1'b0, 1'b1, 7'h01, 32'h0,        8'h00, 1'b1, 32'h0,        1'b0, 1'b0)); // 0 PRIO1 reset
    vecs.push_back(mk(1'b0, 1'b1, 7'h41, 32'h0,        8'h00, 1'b1, 32'h0,        1'b0, 1'b0)); // 1 ENABLE reset
    vecs.push_back(mk(1'b0, 1'b1, 7'h42, 32'h0,        8'h00, 1'b1, 32'h0,        1'b0, 1'b0)); // 2 THRESHOLD reset
    vecs.push_back(mk(1'b1, 1'b0, 7'h01, 32'hFFFFFFFF, 8'h00, 1'b0, 32'h0,        1'b0, 1'b0)); // 3
    vecs.push_back(mk(1'b0, 1'b1, 7'h01, 32'h0,        8'h00, 1'b1, 32'h7,        1'b0, 1'b0)); // 4 PRIO width
    vecs.push_back(mk(1'b1, 1'b0, 7'h41, 32'hFFFFFFFF, 8'h00, 1'b0, 32'h0,        1'b0, 1'b0)); // 5
    vecs.push_back(mk(1'b0, 1'b1, 7'h41, 32'h0,        8'h00, 1'b1, 32'h1FE,      1'b0, 1'b0)); // 6 ENABLE bit0 = 0
    vecs.push_back(mk(1'b1, 1'b0, 7'h44, 32'hFFFFFFFF, 8'h00, 1'b0, 32'h0,        1'b0, 1'b0)); // 7
    vecs.push_back(mk(1'b0, 1'b1, 7'h44, 32'h0,        8'h00, 1'b1, 32'h0,        1'b0, 1'b0)); // 8 unmapped
    vecs.push_back(mk(1'b0, 1'b1, 7'h00, 32'h0,        8'h00, 1'b1, 32'h0,        1'b0, 1'b0)); // 9 addr 0
    vecs.push_back(mk(1'b1, 1'b0, 7'h09, 32'h7,        8'h00, 1'b0, 32'h0,        1'b0, 1'b0)); // 10
    vecs.push_back(mk(1'b0, 1'b1, 7'h09, 32'h0,        8'h00, 1'b1, 32'h0,        1'b0, 1'b0)); // 11 PRIO9 absent
    vecs.push_back(mk(1'b1, 1'b1, 7'h42, 32'h5,        8'h00, 1'b1, 32'h0,        1'b0, 1'b0)); // 12 rd+wr -> old
    vecs.push_back(mk(1'b0, 1'b1, 7'h42, 32'h0,        8'h00, 1'b1, 32'h5,        1'b0, 1'b0)); // 13 new value
    vecs.push_back(mk(1'b1, 1'b0, 7'h03, 32'h5,        8'h00, 1'b0, 32'h0,        1'b0, 1'b0)); // 14 PRIO3=5
    vecs.push_back(mk(1'b1, 1'b0, 7'h05, 32'h5,        8'h00, 1'b0, 32'h0,        1'b0, 1'b0)); // 15 PRIO5=5
    vecs.push_back(mk(1'b1, 1'b0, 7'h41, 32'h28,       8'h00, 1'b0, 32'h0,        1'b0, 1'b0)); // 16 ENABLE
    vecs.push_back(mk(1'b1, 1'b0, 7'h42, 32'h2,        8'h00, 1'b0, 32'h0,        1'b0, 1'b0)); // 17 THRESHOLD
    vecs.push_back(mk(1'b0, 1'b0, 7'h00, 32'h0,        8'h14, 1'b0, 32'h0,        1'b1, 1'b0)); // 18 src 3,5 rise
    vecs.push_back(mk(1'b0, 1'b0, 7'h00, 32'h0,        8'h14, 1'b0, 32'h0,        1'b1, 1'b1)); // 19 irq at t+2
    vecs.push_back(mk(1'b0, 1'b1, 7'h40, 32'h0,        8'h14, 1'b1, 32'h28,       1'b1, 1'b1)); // 20 PENDING
    vecs.push_back(mk(1'b0, 1'b1, 7'h43, 32'h0,        8'h14, 1'b1, 32'h3,        1'b1, 1'b1)); // 21 claim 3
    vecs.push_back(mk(1'b0, 1'b1, 7'h43, 32'h0,        8'h14, 1'b1, 32'h5,        1'b1, 1'b1)); // 22 claim 5
    vecs.push_back(mk(1'b0, 1'b1, 7'h43, 32'h0,        8'h14, 1'b1, 32'h0,        1'b1, 1'b0)); // 23 claim none
    vecs.push_back(mk(1'b0, 1'b1, 7'h40, 32'h0,        8'h14, 1'b1, 32'h0,        1'b0, 1'b0)); // 24 no re-pend
    vecs.push_back(mk(1'b1, 1'b0, 7'h43, 32'h3,        8'h00, 1'b0, 32'h0,        1'b0, 1'b0)); // 25 complete 3
    vecs.push_back(mk(1'b1, 1'b0, 7'h43, 32'h5,        8'h00, 1'b0, 32'h0,        1'b0, 1'b0)); // 26 complete 5
    vecs.push_back(mk(1'b0, 1'b1, 7'h40, 32'h0,        8'h00, 1'b1, 32'h0,        1'b1, 1'b0)); // 27 idle
    vecs.push_back(mk(1'b1, 1'b0, 7'h41, 32'h4,        8'h00, 1'b0, 32'h0,        1'b0, 1'b0)); // 28 ENABLE src2
    vecs.push_back(mk(1'b1, 1'b0, 7'h02, 32'h2,        8'h00, 1'b0, 32'h0,        1'b0, 1'b0)); // 29 PRIO2=2
    vecs.push_back(mk(1'b0, 1'b0, 7'h00, 32'h0,        8'h02, 1'b0, 32'h0,        1'b1, 1'b0)); // 30
    vecs.push_back(mk(1'b0, 1'b0, 7'h00, 32'h0,        8'h02, 1'b0, 32'h0,        1'b1, 1'b0)); // 31 prio == thr
    vecs.push_back(mk(1'b0, 1'b1, 7'h40, 32'h0,        8'h02, 1'b1, 32'h4,        1'b1, 1'b0)); // 32 PENDING
    vecs.push_back(mk(1'b1, 1'b0, 7'h42, 32'h1,        8'h02, 1'b0, 32'h0,        1'b1, 1'b0)); // 33 THRESHOLD=1
    vecs.push_back(mk(1'b0, 1'b0, 7'h00, 32'h0,        8'h02, 1'b0, 32'h0,        1'b1, 1'b1)); // 34 now above
    vecs.push_back(mk(1'b0, 1'b1, 7'h43, 32'h0,        8'h02, 1'b1, 32'h2,        1'b0, 1'b0)); // 35 claim 2
    vecs.push_back(mk(1'b1, 1'b0, 7'h43, 32'h2,        8'h00, 1'b0, 32'h0,        1'b1, 1'b0)); // 36 complete 2

    for (int i = 0; i < vecs.size(); i++) begin
      wr_en = vecs[i].wr; rd_en = vecs[i].rd; addr = vecs[i].addr;
      wdata = vecs[i].wdata; src = vecs[i].src;
      tick();
      if (vecs[i].chk_rd)  check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
      if (vecs[i].chk_irq) check($sformatf("vec%0d_e_irq", i), {31'b0, e_irq}, {31'b0, vecs[i].exp_irq});
    end
    wr_en = 1'b0; rd_en = 1'b0; src = '0;

    // Edge source 8: second edge during service is deferred until complete
    do_write(7'h08, 32'h7);
    do_write(7'h41, 32'h100);
    src = 8'h80; tick();
    src = 8'h00; tick();
    do_read("edge_claim8", 7'h43, 32'h8);
    src = 8'h80; tick();
    src = 8'h00; tick();
    do_read("edge_deferred_not_pending", 7'h40, 32'h0);
    do_write(7'h43, 32'h8);
    do_read("edge_deferred_to_pending", 7'h40, 32'h100);
    do_read("edge_reclaim8", 7'h43, 32'h8);
    do_write(7'h43, 32'h8);
    do_read("edge_idle_after", 7'h40, 32'h0);

    // Level source 4 held high across claim; stray complete is ignored
    do_write(7'h04, 32'h4);
    do_write(7'h41, 32'h10);
    src = 8'h08; tick(); tick();
    do_read("level_claim4", 7'h43, 32'h4);
    tick(); tick();
    do_read("level_no_repend", 7'h40, 32'h0);
    do_write(7'h43, 32'h6);
    do_read("level_claim_after_bad_complete", 7'h43, 32'h0);
    do_read("level_still_in_service", 7'h40, 32'h0);
    do_write(7'h43, 32'h4);
    tick();
    do_read("level_repend_after_complete", 7'h40, 32'h10);
    src = 8'h00;
    do_read("level_claim4_again", 7'h43, 32'h4);
    do_write(7'h43, 32'h4);

    // Reset while source 1 is in service with e_irq asserted
    do_write(7'h41, 32'h2);
    src = 8'h01; tick(); tick();
    do_read("rst_claim1", 7'h43, 32'h1);
    check("rst_e_irq_before", {31'b0, e_irq}, 32'h1);
    rst = 1'b1; tick();
    check("rst_rdata_cleared", rdata, 32'h0);
    check("rst_e_irq_cleared", {31'b0, e_irq}, 32'h0);
    rst = 1'b0;
    do_read("rst_pending_first", 7'h40, 32'h0);
    do_read("rst_src1_repends", 7'h40, 32'h2);
    do_read("rst_prio1", 7'h01, 32'h0);
    do_read("rst_enable", 7'h41, 32'h0);
    do_read("rst_threshold", 7'h42, 32'h0);
    do_read("rst_claim_none", 7'h43, 32'h0);
    check("rst_e_irq_low", {31'b0, e_irq}, 32'h0);
    src = 8'h00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
